// File: rtl/iob_plic_src_cond_pkg.sv
// Shared types and constants for the PLIC interrupt-source conditioner.
package iob_plic_src_cond_pkg;

  // Encoding keeps src (bit 1) and busy (bit 0 ^ bit 1) cheap to decode.
  typedef enum logic [1:0] {
    ST_LOW    = 2'b00,
    ST_RISE_Q = 2'b01,
    ST_HIGH   = 2'b11,
    ST_FALL_Q = 2'b10
  } filt_state_e;

  localparam int GLITCH_W = 8;

endpackage

// File: rtl/iob_plic_src_filter.sv
// One interrupt line: synchronizer, polarity fix, glitch-qualification FSM.
// Optional glitch counter enabled by IOB_PLIC_SRC_COND_GLITCHCNT_EN.
module iob_plic_src_filter
  import iob_plic_src_cond_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 8
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                irq_i,
  input  logic                pol_i,
  input  logic [FILT_W-1:0]   filt_len_i,
`ifdef IOB_PLIC_SRC_COND_GLITCHCNT_EN
  input  logic                glitch_clr_i,
  output logic [GLITCH_W-1:0] glitch_cnt_o,
`endif
  output logic                src_o,
  output logic                qual_d_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  filt_state_e            state_q, state_d;
  logic [FILT_W-1:0]      cnt_q, cnt_d;
  logic                   src_q, src_d;
  logic                   s;
  logic                   glitch;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], irq_i};
  assign s      = sync_q[SYNC_STAGES-1] ^ pol_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    glitch  = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (s) begin
          if (filt_len_i == '0) begin
            state_d = ST_HIGH;
          end else begin
            state_d = ST_RISE_Q;
            cnt_d   = FILT_W'(1);
          end
        end
      end
      ST_RISE_Q: begin
        if (!s) begin
          state_d = ST_LOW;
          glitch  = 1'b1;
        end else if (cnt_q >= filt_len_i) begin
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_q + FILT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!s) begin
          if (filt_len_i == '0) begin
            state_d = ST_LOW;
          end else begin
            state_d = ST_FALL_Q;
            cnt_d   = FILT_W'(1);
          end
        end
      end
      ST_FALL_Q: begin
        if (s) begin
          state_d = ST_HIGH;
          glitch  = 1'b1;
        end else if (cnt_q >= filt_len_i) begin
          state_d = ST_LOW;
        end else begin
          cnt_d = cnt_q + FILT_W'(1);
        end
      end
      default: state_d = ST_LOW;
    endcase
  end

  // Output is registered from the next state so it moves with the FSM.
  assign src_d    = (state_d == ST_HIGH) || (state_d == ST_FALL_Q);
  assign qual_d_o = (state_d == ST_RISE_Q) || (state_d == ST_FALL_Q);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync_q  <= '0;
      state_q <= ST_LOW;
      cnt_q   <= '0;
      src_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
    end
  end

  assign src_o = src_q;

`ifdef IOB_PLIC_SRC_COND_GLITCHCNT_EN
  logic [GLITCH_W-1:0] gcnt_q, gcnt_d;

  // Clear takes priority over a same-cycle increment; count saturates.
  always_comb begin
    gcnt_d = gcnt_q;
    if (glitch_clr_i) begin
      gcnt_d = '0;
    end else if (glitch && (gcnt_q != '1)) begin
      gcnt_d = gcnt_q + GLITCH_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      gcnt_q <= '0;
    end else begin
      gcnt_q <= gcnt_d;
    end
  end

  assign glitch_cnt_o = gcnt_q;
`else
  logic unused_glitch;
  assign unused_glitch = glitch;
`endif

endmodule

// File: rtl/iob_plic_src_cond.sv
// Interrupt-source conditioner feeding the PLIC src input: sync, polarity, filter.
// Optional per-line glitch counters enabled by IOB_PLIC_SRC_COND_GLITCHCNT_EN.
module iob_plic_src_cond
  import iob_plic_src_cond_pkg::*;
#(
  parameter int SOURCES     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 8
) (
  input  logic                         clk_i,
  input  logic                         arst_i,
  input  logic [SOURCES-1:0]           irq_ext_i,
  input  logic [SOURCES-1:0]           pol_i,
  input  logic [FILT_W-1:0]            filt_len_i,
`ifdef IOB_PLIC_SRC_COND_GLITCHCNT_EN
  input  logic                         glitch_clr_i,
  output logic [SOURCES*GLITCH_W-1:0]  glitch_cnt_o,
`endif
  output logic [SOURCES-1:0]           src_o,
  output logic                         busy_o
);

  logic [SOURCES-1:0] qual_d;
  logic               busy_q, busy_d;

  for (genvar n = 0; n < SOURCES; n++) begin : g_line
    iob_plic_src_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W)
    ) u_filter (
      .clk_i        (clk_i),
      .arst_i       (arst_i),
      .irq_i        (irq_ext_i[n]),
      .pol_i        (pol_i[n]),
      .filt_len_i   (filt_len_i),
`ifdef IOB_PLIC_SRC_COND_GLITCHCNT_EN
      .glitch_clr_i (glitch_clr_i),
      .glitch_cnt_o (glitch_cnt_o[n*GLITCH_W +: GLITCH_W]),
`endif
      .src_o        (src_o[n]),
      .qual_d_o     (qual_d[n])
    );
  end

  // Registered from next-state flags so busy_o lines up with the line FSMs.
  assign busy_d = |qual_d;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: doc/iob_plic_src_cond.md
Name: iob_plic_src_cond

Overview:
Interrupt-source conditioner placed directly upstream of the PLIC; its src_o drives the PLIC core's src input.
- Synchronizes asynchronous external interrupt lines into clk_i.
- Applies per-source polarity correction.
- Rejects glitches with a programmable per-block qualification filter.
- Presents clean, active-high, registered level/edge sources to the PLIC gateway.

Parameters:
SOURCES, 8, number of interrupt lines; must match PLIC SOURCES
SYNC_STAGES, 2, synchronizer flops per line (min 2)
FILT_W, 8, width of filter length / qualification counter

Ports:
clk_i  input  1  system clock
arst_i  input  1  asynchronous active-high reset
irq_ext_i  input  SOURCES  raw asynchronous interrupt lines
pol_i  input  SOURCES  per-line polarity; 1 = input active-low (inverted after sync)
filt_len_i  input  FILT_W  qualification length; 0 = filter bypass (1-sample qualify)
src_o  output  SOURCES  conditioned active-high sources to PLIC src
busy_o  output  1  OR of all lines currently in a qualify state

Behaviour:
- Reset: clk_i, arst_i (asynchronous, active-high). All sync flops 0, all FSMs LOW, counters 0, src_o=0, busy_o=0.
- Sync: irq_ext_i[n] passes SYNC_STAGES flops; s[n] = sync_out XOR pol_i[n]. pol_i is quasi-static; a change is treated as an input edge and filtered normally.
- Per-line FSM, 2-bit state: LOW, RISE_Q, HIGH, FALL_Q.
  - LOW:
    - s=1 and filt_len_i=0 -> HIGH.
    - s=1 otherwise -> RISE_Q, cnt=1.
    - s=0 -> stay.
  - RISE_Q:
    - s=0 -> LOW (glitch rejected).
    - s=1 and cnt>=filt_len_i -> HIGH.
    - else cnt<=cnt+1.
  - HIGH: symmetric to LOW with s=0 -> FALL_Q, cnt=1 (or straight to LOW if filt_len_i=0).
  - FALL_Q: symmetric to RISE_Q.
    - s=1 -> HIGH (glitch rejected).
    - s=0 and cnt>=filt_len_i -> LOW.
- Output:
  - src_o[n] is a registered bit, 1 in HIGH and FALL_Q, 0 in LOW and RISE_Q.
  - Transitions only on qualified entry to HIGH or LOW.
- Latency from raw edge to src_o edge: SYNC_STAGES + filt_len_i + 1 cycles. Requires filt_len_i+1 consecutive equal samples.
- filt_len_i changes mid-qualification take effect immediately via the >= compare. Lowering the value can complete a pending qualification on the next cycle.
- cnt never exceeds filt_len_i, so no wrap; filt_len_i = 2^FILT_W-1 is legal.
- busy_o: registered OR over lines in RISE_Q or FALL_Q.
- Lines are fully independent; simultaneous events on all lines are processed in parallel.
- arst_i mid-qualification aborts to LOW; src_o drops asynchronously.

Optional Feature:
IOB_PLIC_SRC_COND_GLITCHCNT_EN
- Defined:
  - Adds ports glitch_clr_i (input, 1) and glitch_cnt_o (output, SOURCES*8).
  - Per-line 8-bit counter increments on each rejected glitch (RISE_Q->LOW or FALL_Q->HIGH) and saturates at 255.
  - glitch_clr_i=1 synchronously zeroes all counters; clear wins over a same-cycle increment.
  - Counters reset to 0 on arst_i.
- Not defined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package iob_plic_src_cond_pkg: FSM state encodings (LOW=2'b00, RISE_Q=2'b01, HIGH=2'b11, FALL_Q=2'b10) and the glitch counter width constant (8).
- Sub-module iob_plic_src_filter: one line's synchronizer, polarity XOR, FSM, counter and optional glitch counter.
  - Top instantiates SOURCES copies via generate and ORs per-line busy flags.

Test Plan:
1. Reset: assert arst_i with irq_ext_i=all 1 -> src_o=0, busy_o=0; after release, filt_len_i=0 -> src_o=all 1 exactly SYNC_STAGES+1 cycles later.
2. Qualify: filt_len_i=4, line 0 high steady -> src_o[0] rises 2+5=7 cycles after edge; low steady -> falls 7 cycles after edge.
3. Glitch: filt_len_i=4, line 3 pulse 3 cycles wide -> src_o[3] stays 0, busy_o pulses, glitch_cnt_o[3]=1 (feature on).
4. Polarity: pol_i[5]=1, irq_ext_i[5]=0 held -> src_o[5]=1 after qualification; irq_ext_i[5]=1 -> src_o[5]=0.
5. Live retune: filt_len_i=200, line 1 in RISE_Q with cnt=10, write filt_len_i=5 -> src_o[1]=1 next cycle.
6. Saturation and clear (feature on): 300 glitches on line 2 -> glitch_cnt_o[2]=255; glitch_clr_i=1 coincident with a glitch -> counter reads 0.
